// File: rtl/lampfpu_tay_arbiter_pkg.sv
// Shared types for the lampFPU_TAY arbiter: FPU opcode set, operand width, arbiter states.
package lampfpu_tay_arbiter_pkg;

    localparam int LAMP_FLOAT_TAY_DW = 16;

    typedef enum logic [3:0] {
        FPU_IDLE = 4'd0,
        FPU_I2F  = 4'd1,
        FPU_F2I  = 4'd2,
        FPU_ADD  = 4'd3,
        FPU_SUB  = 4'd4,
        FPU_MUL  = 4'd5,
        FPU_DIV  = 4'd6,
        FPU_EQ   = 4'd7,
        FPU_LT   = 4'd8,
        FPU_LE   = 4'd9
    } opcodeFPU_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } stateARB_t;

endpackage

// File: rtl/lampfpu_tay_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr_i, cyclically.
// Zero latency; no flow control of its own.
module lampfpu_tay_arbiter_rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lampfpu_tay_arbiter.sv
// Shares one lampFPU_TAY core between N_REQ requesters, one operation in flight at a time.
// Accept->issue 1 cycle, result->response 1 cycle; requests wait while busy or fpu_ready_i=0.
module lampfpu_tay_arbiter
    import lampfpu_tay_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int DW             = LAMP_FLOAT_TAY_DW,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid_i,
    input  opcodeFPU_t       req_opcode_i [N_REQ],
    input  logic [DW-1:0]    req_op1_i    [N_REQ],
    input  logic [DW-1:0]    req_op2_i    [N_REQ],
    output logic [N_REQ-1:0] req_ready_o,
    output logic [N_REQ-1:0] rsp_valid_o,
    output logic [DW-1:0]    rsp_data_o,
    output logic             rsp_err_o,
    output logic             fpu_padv_o,
    output opcodeFPU_t       fpu_opcode_o,
    output logic [DW-1:0]    fpu_op1_o,
    output logic [DW-1:0]    fpu_op2_o,
    input  logic             fpu_ready_i,
    input  logic [DW-1:0]    fpu_result_i,
    input  logic             fpu_result_valid_i
);

    localparam int IW  = $clog2(N_REQ);
    localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IW-1:0]  LAST_REQ = IW'(N_REQ - 1);

    stateARB_t        state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
    opcodeFPU_t       opcode_q, opcode_d;
    logic [DW-1:0]    op1_q, op1_d;
    logic [DW-1:0]    op2_q, op2_d;
    logic             padv_q, padv_d;
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [DW-1:0]    rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             accept;
    logic             wd_hit;
    logic             done;

    lampfpu_tay_arbiter_rr_pick #(.N(N_REQ)) u_rr_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign accept      = (state_q == ARB_IDLE) && fpu_ready_i && pick_any;
    assign req_ready_o = accept ? pick_gnt : '0;

    // A real result in the same cycle as the watchdog expiry wins over the error.
    assign wd_hit = (TIMEOUT_CYCLES > 0) && (wd_cnt_q == WD_LAST);
    assign done   = fpu_result_valid_i || wd_hit;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        wd_cnt_d  = wd_cnt_q;
        opcode_d  = FPU_IDLE;
        op1_d     = op1_q;
        op2_d     = op2_q;
        padv_d    = 1'b0;
        rsp_vld_d = '0;
        rsp_dat_d = '0;
        rsp_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d  = ARB_WAIT;
                    gnt_d    = pick_idx;
                    wd_cnt_d = '0;
                    opcode_d = req_opcode_i[pick_idx];
                    op1_d    = req_op1_i[pick_idx];
                    op2_d    = req_op2_i[pick_idx];
                end
            end
            ARB_WAIT: begin
                if (done) begin
                    state_d   = ARB_IDLE;
                    padv_d    = 1'b1;
                    rsp_vld_d = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
                    rsp_err_d = !fpu_result_valid_i;
                    rsp_dat_d = fpu_result_valid_i ? fpu_result_i : '0;
                    rr_ptr_d  = (gnt_q == LAST_REQ) ? '0 : gnt_q + IW'(1);
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            wd_cnt_q  <= '0;
            opcode_q  <= FPU_IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            padv_q    <= 1'b0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            wd_cnt_q  <= wd_cnt_d;
            opcode_q  <= opcode_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            padv_q    <= padv_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign fpu_opcode_o = opcode_q;
    assign fpu_op1_o    = op1_q;
    assign fpu_op2_o    = op2_q;
    assign fpu_padv_o   = padv_q;
    assign rsp_valid_o  = rsp_vld_q;
    assign rsp_data_o   = rsp_dat_q;
    assign rsp_err_o    = rsp_err_q;

endmodule
